// File: rtl/bus_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : bus_fetch_unit
// Purpose  : Memory-access engine between the CPU fetch/operand port and the
//            system bus. Runs one bus transaction per CPU request with an
//            ack timeout. Keeps a one-entry read buffer so a repeated read of
//            the same word completes without a bus cycle.
// Ports    : clk, W_RST (async, active-low)
//            CPU side : f_enable, f_write_mode, addr, f_data_i, thread ->
//                       f_data_o, f_ack, f_err
//            Bus side : W_ADDR, W_DATA_O, W_WRITE, W_STB, W_TID ->
//                       W_DATA_I, W_ACK
// Revision : 1.0  initial release
// ============================================================================
module bus_fetch_unit #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            TIMEOUT  = 16,
    parameter int            USE_BUF  = 1,
    parameter logic [DW-1:0] ERR_WORD = 32'hDEAD_BEEF
) (
    input  logic          clk,
    input  logic          W_RST,
    input  logic          f_enable,
    input  logic          f_write_mode,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] f_data_i,
    input  logic          thread,
    output logic [DW-1:0] f_data_o,
    output logic          f_ack,
    output logic          f_err,
    output logic [AW-1:0] W_ADDR,
    output logic [DW-1:0] W_DATA_O,
    output logic          W_WRITE,
    output logic          W_STB,
    output logic          W_TID,
    input  logic [DW-1:0] W_DATA_I,
    input  logic          W_ACK
);

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUS     = 2'd1,
        S_DONE    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;

    // Captured request
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_write;
    logic          err_armed;

    // One-entry read buffer
    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data;

    logic [CW-1:0] cnt;
    logic          buf_hit;
    logic          timed_out;

    // Writes never complete from the buffer; they always reach the bus.
    assign buf_hit   = (USE_BUF != 0) && buf_valid && !f_write_mode && (buf_addr == addr);
    // Evaluated only when no ack is present, so an ack on the last cycle wins.
    assign timed_out = (TIMEOUT != 0) && !W_ACK && (cnt == CNT_LAST);

    assign f_ack = (state == S_DONE);
    assign f_err = f_ack && err_armed;

    always_ff @(posedge clk or negedge W_RST) begin
        if (!W_RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (f_enable) begin
                    state_nx = buf_hit ? S_DONE : S_BUS;
                end
            end
            S_BUS: begin
                if (W_ACK || timed_out) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_RELEASE;
            end
            S_RELEASE: begin
                // A request still held high after its ack is not re-issued.
                if (!f_enable) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge W_RST) begin
        if (!W_RST) begin
            f_data_o  <= '0;
            W_ADDR    <= '0;
            W_DATA_O  <= '0;
            W_WRITE   <= 1'b0;
            W_STB     <= 1'b0;
            W_TID     <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_write <= 1'b0;
            err_armed <= 1'b0;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (f_enable) begin
                        req_addr  <= addr;
                        req_wdata <= f_data_i;
                        req_write <= f_write_mode;
                        err_armed <= 1'b0;
                        if (buf_hit) begin
                            f_data_o <= buf_data;
                        end else begin
                            W_ADDR   <= addr;
                            W_DATA_O <= f_data_i;
                            W_WRITE  <= f_write_mode;
                            W_TID    <= thread;
                            W_STB    <= 1'b1;
                            cnt      <= '0;
                        end
                    end
                end
                S_BUS: begin
                    if (W_ACK) begin
                        W_STB <= 1'b0;
                        if (!req_write) begin
                            f_data_o  <= W_DATA_I;
                            buf_addr  <= req_addr;
                            buf_data  <= W_DATA_I;
                            buf_valid <= 1'b1;
                        end else if (buf_addr == req_addr) begin
                            // Write-through keeps the buffered word coherent.
                            buf_data <= req_wdata;
                        end
                    end else begin
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (timed_out) begin
                            W_STB     <= 1'b0;
                            buf_valid <= 1'b0;
                            err_armed <= 1'b1;
                            if (!req_write) begin
                                f_data_o <= ERR_WORD;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_fetch_unit
// Purpose  : Self-checking bench for bus_fetch_unit: vector table of requests
//            with expected strobe length, ack latency, data and error flag,
//            plus hand-written reset, release and mid-transaction reset cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_fetch_unit;

    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        W_RST = 1'b0;
    logic        f_enable = 1'b0;
    logic        f_write_mode = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] f_data_i = '0;
    logic        thread = 1'b0;
    logic [31:0] f_data_o;
    logic        f_ack;
    logic        f_err;
    logic [31:0] W_ADDR;
    logic [31:0] W_DATA_O;
    logic        W_WRITE;
    logic        W_STB;
    logic        W_TID;
    logic [31:0] W_DATA_I = '0;
    logic        W_ACK = 1'b0;

    int total  = 0;
    int passed = 0;

    bus_fetch_unit #(
        .AW(32), .DW(32), .TIMEOUT(16), .USE_BUF(1), .ERR_WORD(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .W_RST(W_RST), .f_enable(f_enable), .f_write_mode(f_write_mode),
        .addr(addr), .f_data_i(f_data_i), .thread(thread), .f_data_o(f_data_o),
        .f_ack(f_ack), .f_err(f_err), .W_ADDR(W_ADDR), .W_DATA_O(W_DATA_O),
        .W_WRITE(W_WRITE), .W_STB(W_STB), .W_TID(W_TID), .W_DATA_I(W_DATA_I),
        .W_ACK(W_ACK)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic        tid;
        int          k;        // wait states before ack (NEVER = no ack)
        logic [31:0] rd;
        int          exp_stb;  // strobe cycles
        int          exp_ack;  // cycle of f_ack counted from the request edge
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic tid, input int k, input logic [31:0] rd,
                                input int es, input int ea, input logic [31:0] ed,
                                input logic ee);
        vec_t v;
        v.we = we; v.a = a; v.d = d; v.tid = tid; v.k = k; v.rd = rd;
        v.exp_stb = es; v.exp_ack = ea; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic run_req(input vec_t v, input int idx);
        int          stb_cnt = 0;
        int          ack_cyc = 0;
        logic        bad = 1'b0;
        logic [31:0] got_d = '0;
        logic        got_e = 1'b0;
        @(negedge clk);
        f_enable = 1'b1; f_write_mode = v.we; addr = v.a; f_data_i = v.d;
        thread = v.tid; W_DATA_I = v.rd; W_ACK = 1'b0;
        @(posedge clk);
        #1;
        // Request inputs change after capture and must be ignored.
        addr = $urandom; f_data_i = $urandom; f_write_mode = ~v.we; thread = ~v.tid;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (f_ack) begin
                ack_cyc = c; got_d = f_data_o; got_e = f_err; W_ACK = 1'b0;
                break;
            end
            if (W_STB) begin
                stb_cnt++;
                if (W_ADDR !== v.a || W_WRITE !== v.we || W_TID !== v.tid ||
                    (v.we && W_DATA_O !== v.d)) bad = 1'b1;
            end
            W_ACK = W_STB && (stb_cnt == v.k + 1);
        end
        check($sformatf("v%0d strobe_cycles", idx), stb_cnt, v.exp_stb);
        check($sformatf("v%0d ack_latency", idx), ack_cyc, v.exp_ack);
        check($sformatf("v%0d data", idx), got_d, v.exp_data);
        check($sformatf("v%0d err", idx), {31'd0, got_e}, {31'd0, v.exp_err});
        check($sformatf("v%0d bus_fields", idx), {31'd0, bad}, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d ack_one_cycle", idx), {31'd0, f_ack}, 32'd0);
        f_enable = 1'b0;
    endtask

    initial begin
        logic bad;
        int   cnt;
        logic seen;

        tbl[0]  = mk(0, 32'h100, 32'h0,        0, 0,     32'h12345678, 1,  2,  32'h12345678, 0);
        tbl[1]  = mk(1, 32'h100, 32'hCAFEF00D, 1, 3,     32'h0,        4,  5,  32'h12345678, 0);
        tbl[2]  = mk(0, 32'h100, 32'h0,        0, 0,     32'h0,        0,  1,  32'hCAFEF00D, 0);
        tbl[3]  = mk(0, 32'h200, 32'h0,        1, NEVER, 32'h0,        16, 17, 32'hDEADBEEF, 1);
        tbl[4]  = mk(0, 32'h200, 32'h0,        0, 1,     32'h0BADF00D, 2,  3,  32'h0BADF00D, 0);
        tbl[5]  = mk(0, 32'h200, 32'h0,        1, 0,     32'h0,        0,  1,  32'h0BADF00D, 0);
        tbl[6]  = mk(1, 32'h300, 32'h55555555, 0, 0,     32'h0,        1,  2,  32'h0BADF00D, 0);
        tbl[7]  = mk(0, 32'h200, 32'h0,        1, 0,     32'h0,        0,  1,  32'h0BADF00D, 0);
        tbl[8]  = mk(1, 32'h200, 32'h12121212, 0, NEVER, 32'h0,        16, 17, 32'h0BADF00D, 1);
        tbl[9]  = mk(0, 32'h200, 32'h0,        1, 2,     32'h77777777, 3,  4,  32'h77777777, 0);
        tbl[10] = mk(0, 32'h400, 32'h0,        0, 15,    32'hA5A5A5A5, 16, 17, 32'hA5A5A5A5, 0);
        tbl[11] = mk(0, 32'h600, 32'h0,        1, 0,     32'h66666666, 1,  2,  32'h66666666, 0);

        // Reset held with active-looking inputs: everything stays 0.
        f_enable = 1'b1; W_ACK = 1'b1; addr = 32'h100; f_data_i = 32'hFFFFFFFF;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (f_data_o !== '0 || f_ack !== 1'b0 || f_err !== 1'b0 || W_ADDR !== '0 ||
                W_DATA_O !== '0 || W_WRITE !== 1'b0 || W_STB !== 1'b0 || W_TID !== 1'b0)
                bad = 1'b1;
        end
        check("reset_outputs_zero", {31'd0, bad}, 32'd0);
        f_enable = 1'b0; W_ACK = 1'b0;
        W_RST = 1'b1;

        for (int i = 0; i < 12; i++) run_req(tbl[i], i);

        // Release rule: request held high after ack is not re-issued.
        @(negedge clk);
        f_enable = 1'b1; f_write_mode = 1'b1; addr = 32'h500; f_data_i = 32'h5; W_ACK = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (f_ack) begin seen = 1'b1; break; end
            W_ACK = W_STB;
        end
        check("release_first_ack", {31'd0, seen}, 32'd1);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            W_ACK = 1'b1;   // ack outside a transaction is ignored
            if (W_STB || f_ack) cnt++;
        end
        check("release_no_reissue", cnt, 0);
        f_enable = 1'b0; W_ACK = 1'b0;
        @(negedge clk);
        f_enable = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (W_STB) begin seen = 1'b1; W_ACK = 1'b1; break; end
        end
        check("release_new_strobe", {31'd0, seen}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (f_ack) break;
            W_ACK = W_STB;
        end
        W_ACK = 1'b0;
        @(negedge clk);
        f_enable = 1'b0;

        // Reset in wait state 2 of a read.
        @(negedge clk);
        f_enable = 1'b1; f_write_mode = 1'b0; addr = 32'h700; W_ACK = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (W_STB) cnt++;
            if (cnt == 3) break;
        end
        check("midbus_strobe_reached", cnt, 3);
        W_RST = 1'b0;
        #1;
        check("midbus_strobe_async_drop", {31'd0, W_STB}, 32'd0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (f_ack) cnt++;
        end
        check("midbus_no_ack", cnt, 0);
        f_enable = 1'b0;
        W_RST = 1'b1;
        // Buffer was cleared: 0x600 must go to the bus again.
        run_req(mk(0, 32'h600, 32'h0, 0, 0, 32'h99999999, 1, 2, 32'h99999999, 0), 12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/bus_fetch_unit.md
Name: bus_fetch_unit

Overview:
- Memory-access engine between the CPU core's operand/instruction fetch port and the system bus.
- Accepts one CPU request at a time (read or write) and runs a single bus transaction with an ack timeout.
- Returns data with a one-cycle ack pulse.
- Holds a one-entry read buffer so repeated reads of the same word (instruction, then operand at the same address) complete without a bus cycle.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, bus cycles to wait for W_ACK before aborting; 0 = wait forever.
- USE_BUF, 1, 1 enables the one-entry read buffer; 0 sends every read to the bus.
- ERR_WORD, 32'hDEAD_BEEF, value returned on f_data_o for a timed-out read.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- W_RST  in  1  reset, asynchronous, active-low.
- f_enable  in  1  CPU request, level; held high until f_ack is seen.
- f_write_mode  in  1  1 = write, 0 = read; sampled with the request.
- addr  in  AW  request address.
- f_data_i  in  DW  write data.
- thread  in  1  requesting thread id; forwarded to the bus.
- f_data_o  out  DW  read data; valid when f_ack = 1, held until the next completion.
- f_ack  out  1  one-cycle completion pulse.
- f_err  out  1  high together with f_ack when the transaction timed out.
- W_ADDR  out  AW  bus address.
- W_DATA_O  out  DW  bus write data.
- W_WRITE  out  1  bus write qualifier; valid while W_STB = 1.
- W_STB  out  1  bus transaction strobe.
- W_TID  out  1  bus thread id.
- W_DATA_I  in  DW  bus read data.
- W_ACK  in  1  bus ack, sampled only while W_STB = 1.

Behaviour:
- Reset (W_RST = 0, asynchronous):
  - state = IDLE.
  - All outputs 0 (f_data_o, f_ack, f_err, W_ADDR, W_DATA_O, W_WRITE, W_STB, W_TID).
  - Read buffer invalid; timeout counter 0.
  - Reset asserted mid-transaction drops W_STB immediately; no ack is produced.
- State machine:
  - IDLE, f_enable = 1:
    - Capture addr, f_data_i, f_write_mode, thread.
    - Read hit (USE_BUF = 1, buffer valid, buffer address = addr): f_data_o <= buffer data; go DONE.
    - Otherwise: load W_ADDR / W_DATA_O / W_WRITE / W_TID, set W_STB = 1, clear the counter, go BUS.
  - BUS, W_ACK = 1:
    - W_STB <= 0.
    - Read: f_data_o <= W_DATA_I; buffer <= {addr, W_DATA_I}, valid.
    - Write: if buffer address matches, buffer data <= written data (write-through).
    - Go DONE.
  - BUS, W_ACK = 0:
    - Counter increments.
    - TIMEOUT != 0 and counter reaches TIMEOUT-1: W_STB <= 0, buffer invalidated, f_err armed, f_data_o <= ERR_WORD on a read (unchanged on a write); go DONE.
  - DONE: f_ack = 1 (and f_err if armed) for exactly one cycle; go RELEASE.
  - RELEASE: wait for f_enable = 0, then go IDLE. A request still held high after the ack is never re-issued.
- Latency, request first sampled at edge N:
  - Buffer hit: f_ack high in cycle N+1.
  - Bus access with k wait states: W_STB high for cycles N+1 .. N+1+k; f_ack high in cycle N+2+k.
- Stability and boundaries:
  - addr, f_data_i, f_write_mode and thread changes after capture are ignored until the next IDLE.
  - W_ADDR, W_DATA_O, W_WRITE and W_TID stay stable for the whole strobe.
  - W_ACK outside BUS is ignored.
  - W_ACK on the timeout cycle: ack wins, normal completion.
  - Write never hits the buffer for completion; it always goes to the bus.
  - Counter saturates and does not wrap; with TIMEOUT = 0 it is unused.

Test Plan:
1. Reset: hold W_RST = 0, drive W_ACK = 1 and f_enable = 1 -> all outputs 0, W_STB never asserts; release reset -> first request starts normally.
2. Read, 0 wait: addr = 0x100, bus returns 0x12345678 with W_ACK on the first strobe cycle -> W_STB high 1 cycle, W_ADDR = 0x100, W_WRITE = 0; f_ack one cycle later with f_data_o = 0x12345678, f_err = 0.
3. Read hit after write-through: read 0x100, then write 0xCAFEF00D to 0x100 (3 wait states, W_STB high 4 cycles, W_WRITE = 1), then read 0x100 -> third request gives no W_STB, f_ack the cycle after the request, f_data_o = 0xCAFEF00D.
4. Timeout: TIMEOUT = 16, read 0x200, W_ACK held 0 -> W_STB high exactly 16 cycles, then f_ack = f_err = 1 for one cycle, f_data_o = 0xDEADBEEF; next read of 0x200 goes to the bus.
5. Release rule: keep f_enable high for 10 cycles after f_ack -> no second W_STB; drop f_enable for 1 cycle and raise it -> new transaction starts.
6. Reset mid-BUS: assert W_RST during wait state 2 of a read -> W_STB drops asynchronously, no f_ack, buffer invalid (a following read of the same address uses the bus).
